debug_probe: RTL and testbench
==============================

Name: debug_probe

Overview:
- Board-side debug sequencer for the single-cycle MIPS core.
- It plays the role of the stepping bench in hardware. On a start request it issues a programmed number of CPU clock pulses on the core's CLK input.
- It then sweeps the core's SEL[2:0] debug selector through 0..7 and samples the 8-bit LED readout at each setting.
- The eight bytes are assembled into a 64-bit snapshot and handed to a host-side consumer via a valid/ready handshake.

Parameters:
- STEP_HALF, 2, system-clock cycles per CPU_CLK half-period; legal range 1..255.
- SEL_SETTLE, 1, system-clock cycles SEL is held stable before LED is sampled; legal range 1..15.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle request; accepted only in IDLE.
- STEPS  in  8  number of CPU clock pulses to issue; captured when START is accepted; 0 means readout only.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- CPU_CLK  out  1  stepped clock to the core; registered output.
- SEL  out  3  debug selector to the core.
- LED  in  8  debug byte from the core.
- SNAP  out  64  snapshot; byte k = LED sampled with SEL=k.
- SNAP_VALID  out  1  snapshot available.
- SNAP_READY  in  1  consumer accepts the snapshot.

Behaviour:
- Reset values: CPU_CLK=0, SEL=0, SNAP=0, SNAP_VALID=0, BUSY=0; FSM in IDLE; internal step and settle counters 0.
- Reset is honoured mid-operation. It aborts any pulse immediately (CPU_CLK forced low) and discards any partial snapshot.
- FSM states: IDLE, HIGH, LOW, SELECT, SAMPLE, PRESENT.
- IDLE:
  - START=1 captures STEPS into the remaining-pulse count.
  - Count nonzero: go to HIGH.
  - Count zero: go to SELECT with SEL=0.
  - START while not IDLE is ignored (no queueing).
- HIGH: CPU_CLK=1 for exactly STEP_HALF cycles, then go to LOW.
- LOW:
  - CPU_CLK=0 for exactly STEP_HALF cycles.
  - At the end, decrement the count.
  - Count reaches 0: go to SELECT with SEL=0. Otherwise go to HIGH.
  - Every pulse is therefore a complete 0→1→0 sequence, and CPU_CLK is never left high outside HIGH.
- SELECT: hold SEL for SEL_SETTLE cycles, then go to SAMPLE.
- SAMPLE (one cycle):
  - Write LED into SNAP byte SEL (SNAP[8*SEL +: 8]).
  - SEL=7: go to PRESENT.
  - Otherwise increment SEL and return to SELECT.
- PRESENT:
  - SNAP_VALID=1; SNAP is stable while SNAP_VALID=1.
  - When SNAP_VALID && SNAP_READY, SNAP_VALID drops on the next edge, SEL returns to 0 and the FSM returns to IDLE.
  - SNAP holds its last value until the next capture overwrites it byte by byte.
  - SNAP_READY is ignored outside PRESENT.
- Latency for a START-to-SNAP_VALID rise:
  - 1 + STEPS·2·STEP_HALF + 8·(SEL_SETTLE+1) cycles.
  - With defaults and STEPS=4: 1+16+16 = 33 cycles.
- STEPS=255: exactly 255 pulses, no wrap of the 8-bit counter.
- BUSY is registered and rises the cycle after START is accepted.

Optional Feature:
- Macro DEBUG_PROBE_CYCLE_COUNT_EN.
- Defined:
  - Adds output CYCLES (32 bits): the total CPU_CLK rising edges issued since reset.
  - Increments on entry to HIGH.
  - Wraps modulo 2^32.
  - Reset value 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package debug_probe_pkg holds:
  - the FSM state enum;
  - SEL_W=3, LED_W=8, SNAP_W=64;
  - NUM_SEL=8.
- One natural sub-module, debug_step_gen:
  - owns the HIGH/LOW half-period counter and the remaining-pulse counter;
  - inputs: go, steps; outputs: CPU_CLK and a done strobe;
  - same CLK/RST.

Test Plan:
1. Core model returns LED = {SEL,5'h0A}; START with STEPS=4 and defaults.
   - Required: exactly 4 CPU_CLK pulses, each 2 cycles high and 2 low.
   - SNAP_VALID rises 33 cycles after START.
   - SNAP = 64'hEACAAA8A6A4A2A0A.
2. STEPS=0.
   - Required: no CPU_CLK edge.
   - SNAP_VALID rises after 17 cycles with the same SNAP.
3. Hold SNAP_READY=0 for 20 cycles in PRESENT.
   - Required: SNAP_VALID and SNAP stay stable.
   - Then assert READY: SNAP_VALID=0 and BUSY=0 next edge.
4. Assert RST asynchronously during the second HIGH phase (STEPS=4).
   - Required: CPU_CLK=0 immediately and all outputs at reset values.
   - A later START with STEPS=1 issues exactly 1 pulse.
5. Pulse START repeatedly while BUSY.
   - Required: the pulse count equals the first STEPS only; no second run.
6. With DEBUG_PROBE_CYCLE_COUNT_EN defined, run STEPS=3, then STEPS=255.
   - Required: CYCLES=3, then 258.
   - Without the macro, the bench compiles without CYCLES.

Source files
------------

// File: rtl/debug_probe_pkg.sv
// Shared types and widths for the debug_probe sequencer.
// Optional feature macro: DEBUG_PROBE_CYCLE_COUNT_EN (CYCLES output on the top).
package debug_probe_pkg;

   localparam int SEL_W   = 3;
   localparam int LED_W   = 8;
   localparam int SNAP_W  = 64;
   localparam int NUM_SEL = 8;

   typedef enum logic [2:0] {
      IDLE,
      HIGH,
      LOW,
      SELECT,
      SAMPLE,
      PRESENT
   } state_t;

endpackage

// File: rtl/debug_step_gen.sv
// Stepped CPU clock generator: issues 'steps' complete 0->1->0 pulses,
// each half-period lasting STEP_HALF system clocks.
// half_end marks the last cycle of any half-period.
// done marks the last cycle of the final low half.
module debug_step_gen #(
   parameter int STEP_HALF = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       go,
   input  logic [7:0] steps,
   output logic       cpu_clk,
   output logic       half_end,
   output logic       done
);

   logic       active;
   logic [7:0] half_cnt;
   logic [7:0] remaining;

   assign half_end = active && (half_cnt == 8'(STEP_HALF - 1));
   assign done     = half_end && !cpu_clk && (remaining == 8'd1);

   // Half-period timing and pulse countdown; a pulse always ends low before the count drops
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         active    <= 1'b0;
         cpu_clk   <= 1'b0;
         half_cnt  <= 8'd0;
         remaining <= 8'd0;
      end else if (!active) begin
         if (go && (steps != 8'd0)) begin
            active    <= 1'b1;
            cpu_clk   <= 1'b1;
            half_cnt  <= 8'd0;
            remaining <= steps;
         end
      end else if (half_end) begin
         half_cnt <= 8'd0;
         if (cpu_clk) begin
            cpu_clk <= 1'b0;
         end else begin
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) begin
               active <= 1'b0;
            end else begin
               cpu_clk <= 1'b1;
            end
         end
      end else begin
         half_cnt <= half_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/debug_probe.sv
// Board-side debug sequencer: steps the core clock, sweeps SEL 0..7,
// samples LED into a 64-bit snapshot and offers it over valid/ready.
// Optional feature macro: DEBUG_PROBE_CYCLE_COUNT_EN adds the CYCLES output.
module debug_probe
   import debug_probe_pkg::*;
#(
   parameter int STEP_HALF  = 2,
   parameter int SEL_SETTLE = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic [7:0]        STEPS,
   output logic              BUSY,
   output logic              CPU_CLK,
   output logic [SEL_W-1:0]  SEL,
   input  logic [LED_W-1:0]  LED,
   output logic [SNAP_W-1:0] SNAP,
   output logic              SNAP_VALID,
   input  logic              SNAP_READY
`ifdef DEBUG_PROBE_CYCLE_COUNT_EN
   ,
   output logic [31:0]       CYCLES
`endif
);

   state_t           state;
   logic [SEL_W-1:0] sel;
   logic [3:0]       settle_cnt;
   logic [SNAP_W-1:0] snap;
   logic             snap_valid;
   logic             busy;
   logic             go;
   logic             half_end;
   logic             done;

   assign go         = (state == IDLE) && START && (STEPS != 8'd0);
   assign BUSY       = busy;
   assign SEL        = sel;
   assign SNAP       = snap;
   assign SNAP_VALID = snap_valid;

   debug_step_gen #(
      .STEP_HALF (STEP_HALF)
   ) u_step_gen (
      .CLK      (CLK),
      .RST      (RST),
      .go       (go),
      .steps    (STEPS),
      .cpu_clk  (CPU_CLK),
      .half_end (half_end),
      .done     (done)
   );

   // Sequencer: stepping phases follow the generator, then the SEL sweep and the handshake
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         sel        <= '0;
         settle_cnt <= 4'd0;
         snap       <= '0;
         snap_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  busy <= 1'b1;
                  if (STEPS != 8'd0) begin
                     state <= HIGH;
                  end else begin
                     state      <= SELECT;
                     sel        <= '0;
                     settle_cnt <= 4'd0;
                  end
               end
            end
            HIGH: begin
               if (half_end) begin
                  state <= LOW;
               end
            end
            LOW: begin
               if (done) begin
                  state      <= SELECT;
                  sel        <= '0;
                  settle_cnt <= 4'd0;
               end else if (half_end) begin
                  state <= HIGH;
               end
            end
            SELECT: begin
               if (settle_cnt == 4'(SEL_SETTLE - 1)) begin
                  settle_cnt <= 4'd0;
                  state      <= SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end
            SAMPLE: begin
               snap[{sel, 3'b000} +: LED_W] <= LED;
               if (sel == SEL_W'(NUM_SEL - 1)) begin
                  snap_valid <= 1'b1;
                  state      <= PRESENT;
               end else begin
                  sel   <= sel + 1'b1;
                  state <= SELECT;
               end
            end
            PRESENT: begin
               if (SNAP_READY) begin
                  snap_valid <= 1'b0;
                  sel        <= '0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef DEBUG_PROBE_CYCLE_COUNT_EN
   logic        enter_high;
   logic [31:0] cycles;

   assign enter_high = go || ((state == LOW) && half_end && !done);
   assign CYCLES     = cycles;

   // Running total of CPU_CLK rising edges since reset, wrapping at 2^32
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cycles <= 32'd0;
      end else if (enter_high) begin
         cycles <= cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_debug_probe.sv
// Scoreboard bench for debug_probe: a stimulus process queues the expected
// snapshot, pulse count and latency; a monitor pops and compares on each
// SNAP_VALID rise. Build with DEBUG_PROBE_CYCLE_COUNT_EN to also check CYCLES.
module tb_debug_probe;

   localparam int STEP_HALF  = 2;
   localparam int SEL_SETTLE = 1;

   typedef struct {
      logic [63:0] snap;
      int          pulses;
      int          latency;
      int          start_edge;
      logic [31:0] cycles;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic        START;
   logic [7:0]  STEPS;
   logic        BUSY;
   logic        CPU_CLK;
   logic [2:0]  SEL;
   logic [7:0]  LED;
   logic [63:0] SNAP;
   logic        SNAP_VALID;
   logic        SNAP_READY;
`ifdef DEBUG_PROBE_CYCLE_COUNT_EN
   logic [31:0] CYCLES;
`endif

   logic [7:0]  led_table [8];
   exp_t        exp_q [$];
   int          checks = 0;
   int          errors = 0;
   int          edge_cnt = 0;
   int          total_pulses = 0;

   assign LED = led_table[SEL];

   debug_probe #(
      .STEP_HALF  (STEP_HALF),
      .SEL_SETTLE (SEL_SETTLE)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .START      (START),
      .STEPS      (STEPS),
      .BUSY       (BUSY),
      .CPU_CLK    (CPU_CLK),
      .SEL        (SEL),
      .LED        (LED),
      .SNAP       (SNAP),
      .SNAP_VALID (SNAP_VALID),
      .SNAP_READY (SNAP_READY)
`ifdef DEBUG_PROBE_CYCLE_COUNT_EN
      ,
      .CYCLES     (CYCLES)
`endif
   );

   // Free-running system clock
   always #5 CLK = ~CLK;

   // Rising-edge counter used as the time base for latency
   initial begin
      forever begin
         @(posedge CLK);
         edge_cnt = edge_cnt + 1;
      end
   end

   // Hard stop in case something hangs
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks = checks + 1;
      if (act !== req) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic loadCoreTable();
      for (int k = 0; k < 8; k++) led_table[k] = {3'(k), 5'h0A};
   endtask

   task automatic loadRandomTable();
      for (int k = 0; k < 8; k++) led_table[k] = 8'($urandom);
   endtask

   task automatic doReset();
      #2;
      RST        = 1'b1;
      START      = 1'b0;
      STEPS      = 8'd0;
      SNAP_READY = 1'b0;
      total_pulses = 0;
      @(negedge CLK);
      @(negedge CLK);
      checkOutput("reset_cpu_clk", 64'(CPU_CLK), 64'd0);
      checkOutput("reset_sel", 64'(SEL), 64'd0);
      checkOutput("reset_snap", SNAP, 64'd0);
      checkOutput("reset_snap_valid", 64'(SNAP_VALID), 64'd0);
      checkOutput("reset_busy", 64'(BUSY), 64'd0);
`ifdef DEBUG_PROBE_CYCLE_COUNT_EN
      checkOutput("reset_cycles", 64'(CYCLES), 64'd0);
`endif
      RST = 1'b0;
   endtask

   // One full transaction: queue expectation, pulse START, optionally spam START while busy,
   // wait for the snapshot, stall READY, then complete the handshake
   task automatic applyStimulus(input int steps, input int ready_delay, input int extra_starts);
      exp_t e;
      int   n;
      @(negedge CLK);
      for (int k = 0; k < 8; k++) e.snap[8*k +: 8] = led_table[k];
      total_pulses = total_pulses + steps;
      e.pulses     = steps;
      e.latency    = 1 + steps * 2 * STEP_HALF + 8 * (SEL_SETTLE + 1);
      e.start_edge = edge_cnt;
      e.cycles     = 32'(total_pulses);
      exp_q.push_back(e);
      START = 1'b1;
      STEPS = 8'(steps);
      @(negedge CLK);
      START = 1'b0;
      STEPS = 8'($urandom);
      checkOutput("busy_rise", 64'(BUSY), 64'd1);
      for (int i = 0; i < extra_starts; i++) begin
         @(negedge CLK);
         START = 1'b1;
         STEPS = 8'd9;
         @(negedge CLK);
         START = 1'b0;
      end
      n = 0;
      while (!SNAP_VALID && n < 5000) begin
         @(negedge CLK);
         n = n + 1;
      end
      if (!SNAP_VALID) checkOutput("valid_timeout", 64'(SNAP_VALID), 64'd1);
      for (int i = 0; i < ready_delay; i++) begin
         checkOutput("hold_valid", 64'(SNAP_VALID), 64'd1);
         checkOutput("hold_snap", SNAP, e.snap);
         @(negedge CLK);
      end
      SNAP_READY = 1'b1;
      @(negedge CLK);
      SNAP_READY = 1'b0;
      checkOutput("ack_valid_low", 64'(SNAP_VALID), 64'd0);
      checkOutput("ack_busy_low", 64'(BUSY), 64'd0);
   endtask

   // Reset asserted between clock edges during the second high phase of a 4-pulse run
   task automatic midRunReset();
      int rises;
      int n;
      bit prev;
      @(negedge CLK);
      START = 1'b1;
      STEPS = 8'd4;
      @(negedge CLK);
      START = 1'b0;
      rises = 0;
      n     = 0;
      prev  = 1'b0;
      while (rises < 2 && n < 200) begin
         if (CPU_CLK && !prev) rises = rises + 1;
         prev = CPU_CLK;
         if (rises < 2) begin
            @(negedge CLK);
            n = n + 1;
         end
      end
      checkOutput("second_pulse_seen", 64'(rises), 64'd2);
      checkOutput("second_pulse_high", 64'(CPU_CLK), 64'd1);
      #2;
      RST = 1'b1;
      total_pulses = 0;
      #1;
      checkOutput("async_cpu_clk", 64'(CPU_CLK), 64'd0);
      checkOutput("async_busy", 64'(BUSY), 64'd0);
      checkOutput("async_sel", 64'(SEL), 64'd0);
      checkOutput("async_snap", SNAP, 64'd0);
      checkOutput("async_snap_valid", 64'(SNAP_VALID), 64'd0);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   // Monitor: pulse shape, pulse count, and scoreboard pop on every snapshot presentation
   initial begin
      bit   cpu_prev;
      bit   valid_prev;
      int   high_run;
      int   low_run;
      int   run_pulses;
      exp_t e;
      cpu_prev   = 1'b0;
      valid_prev = 1'b0;
      high_run   = 0;
      low_run    = 0;
      run_pulses = 0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            exp_q.delete();
            cpu_prev   = 1'b0;
            valid_prev = 1'b0;
            high_run   = 0;
            low_run    = 0;
            run_pulses = 0;
         end else begin
            if (CPU_CLK && !cpu_prev) begin
               if (run_pulses > 0) checkOutput("low_width", 64'(low_run), 64'(STEP_HALF));
               run_pulses = run_pulses + 1;
               high_run   = 1;
            end else if (!CPU_CLK && cpu_prev) begin
               checkOutput("high_width", 64'(high_run), 64'(STEP_HALF));
               low_run = 1;
            end else if (CPU_CLK) begin
               high_run = high_run + 1;
            end else begin
               low_run = low_run + 1;
            end
            cpu_prev = CPU_CLK;
            if (SNAP_VALID && !valid_prev) begin
               if (exp_q.size() == 0) begin
                  checkOutput("unexpected_snapshot", 64'(SNAP_VALID), 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("snap_value", SNAP, e.snap);
                  checkOutput("pulse_count", 64'(run_pulses), 64'(e.pulses));
                  checkOutput("latency", 64'(edge_cnt - e.start_edge), 64'(e.latency));
`ifdef DEBUG_PROBE_CYCLE_COUNT_EN
                  checkOutput("cycles", 64'(CYCLES), 64'(e.cycles));
`endif
               end
               run_pulses = 0;
            end
            valid_prev = SNAP_VALID;
         end
      end
   end

   // Test sequence
   initial begin
      RST        = 1'b1;
      START      = 1'b0;
      STEPS      = 8'd0;
      SNAP_READY = 1'b0;
      loadCoreTable();
      doReset();

      $display("[TB] directed STEPS=4 and STEPS=0 with core pattern");
      applyStimulus(4, 0, 0);
      applyStimulus(0, 0, 0);

      $display("[TB] stalled READY for 20 cycles");
      loadRandomTable();
      applyStimulus(2, 20, 0);

      $display("[TB] randomized runs");
      for (int r = 0; r < 6; r++) begin
         loadRandomTable();
         applyStimulus(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), 0);
      end

      $display("[TB] START pulses while busy");
      loadRandomTable();
      applyStimulus(3, 1, 4);
      repeat (30) @(negedge CLK);
      checkOutput("no_second_run_busy", 64'(BUSY), 64'd0);
      checkOutput("no_second_run_valid", 64'(SNAP_VALID), 64'd0);

      $display("[TB] asynchronous reset mid-pulse");
      loadRandomTable();
      midRunReset();
      applyStimulus(1, 0, 0);

      $display("[TB] cycle totals: STEPS=3 then STEPS=255");
      doReset();
      loadCoreTable();
      applyStimulus(3, 0, 0);
      loadRandomTable();
      applyStimulus(255, 2, 0);
`ifdef DEBUG_PROBE_CYCLE_COUNT_EN
      checkOutput("cycles_total", 64'(CYCLES), 64'(total_pulses));
`endif

      repeat (5) @(negedge CLK);
      checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
